mor1kx_pic_multimode: RTL and testbench

- Parametrised successor PIC for the mor1kx SPR bus.
- Supports 1..32 IRQ lines. Each line's trigger mode (level, edge, latched-level) is selected at run time through SPRs rather than by one global build option.
- Adds a registered priority encoder that reports the lowest-numbered pending line to the exception unit and to software.
- Sits beside the control unit on SPR group 9; drives picmr/picsr into the interrupt-exception logic.

---
 rtl/mor1kx_pic_pkg.sv | 31 +++
 rtl/mor1kx_pic_multimode_if.sv | 19 +
 rtl/mor1kx_pic_prio_enc.sv | 24 ++
 rtl/mor1kx_pic_multimode.sv | 156 +++++++++++++++
 tb/tb_mor1kx_pic_multimode.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mor1kx_pic_pkg.sv
// rtl/mor1kx_pic_pkg.sv - SPR offsets, trigger-mode encodings and PICID layout for the multimode PIC
package mor1kx_pic_pkg;

   localparam logic [10:0] SPR_OFS_PICMR    = 11'd0;
   localparam logic [10:0] SPR_OFS_PICSR    = 11'd2;
   localparam logic [10:0] SPR_OFS_PICEDGE  = 11'd4;
   localparam logic [10:0] SPR_OFS_PICLATCH = 11'd5;
   localparam logic [10:0] SPR_OFS_PICID    = 11'd6;

   typedef enum logic [1:0] {
      TRIG_LEVEL   = 2'd0,
      TRIG_EDGE    = 2'd1,
      TRIG_LATCHED = 2'd2,
      TRIG_INVALID = 2'd3
   } trig_mode_e;

   localparam int PICID_PEND_BIT = 31;
   localparam int PICID_ID_LSB   = 0;
   localparam int PICID_ID_W     = 5;

   // Mask with the n lowest bits set, saturating at the 32-bit SPR width.
   function automatic logic [31:0] low_ones(input int n);
      if (n <= 0)
         return 32'h0;
      else if (n >= 32)
         return 32'hFFFF_FFFF;
      else
         return (32'd1 << n) - 32'd1;
   endfunction

endpackage

// File: rtl/mor1kx_pic_multimode_if.sv
// rtl/mor1kx_pic_multimode_if.sv - SPR bus bundle between the control unit and the PIC
interface mor1kx_pic_multimode_if;
   logic        spr_access_i;
   logic        spr_we_i;
   logic [15:0] spr_addr_i;
   logic [31:0] spr_dat_i;
   logic        spr_bus_ack;
   logic [31:0] spr_dat_o;

   modport master (
      output spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
      input  spr_bus_ack, spr_dat_o
   );

   modport slave (
      input  spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
      output spr_bus_ack, spr_dat_o
   );
endinterface

// File: rtl/mor1kx_pic_prio_enc.sv
// rtl/mor1kx_pic_prio_enc.sv - combinational lowest-index-first priority encoder
module mor1kx_pic_prio_enc
   import mor1kx_pic_pkg::*;
#(
   parameter int NUM_IRQ = 32
) (
   input  logic [NUM_IRQ-1:0]    req_i,
   output logic                  valid_o,
   output logic [PICID_ID_W-1:0] id_o
);

   // Scanning downward lets the lowest set index overwrite any higher one.
   always_comb begin
      valid_o = 1'b0;
      id_o    = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            valid_o = 1'b1;
            id_o    = i[PICID_ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mor1kx_pic_multimode.sv
// rtl/mor1kx_pic_multimode.sv - SPR group 9 PIC with per-line trigger modes; MOR1KX_PIC_SYNC_EN adds a 2-flop irq synchroniser
module mor1kx_pic_multimode
   import mor1kx_pic_pkg::*;
#(
   parameter int    NUM_IRQ              = 32,
   parameter int    OPTION_PIC_NMI_WIDTH = 0,
   parameter string OPTION_PIC_TRIGGER   = "LEVEL"
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mor1kx_pic_multimode_if.slave  spr,
   input  logic [31:0]            irq_i,
   output logic [31:0]            spr_picmr_o,
   output logic [31:0]            spr_picsr_o,
   output logic                   irq_pending_o,
   output logic [PICID_ID_W-1:0]  irq_id_o
);

   localparam trig_mode_e RST_MODE =
      (OPTION_PIC_TRIGGER == "LEVEL")         ? TRIG_LEVEL   :
      (OPTION_PIC_TRIGGER == "EDGE")          ? TRIG_EDGE    :
      (OPTION_PIC_TRIGGER == "LATCHED_LEVEL") ? TRIG_LATCHED : TRIG_INVALID;

   localparam logic [31:0] IMPL_MASK = low_ones(NUM_IRQ);
   localparam logic [31:0] NMI_MASK  = low_ones(OPTION_PIC_NMI_WIDTH) & IMPL_MASK;
   localparam logic [31:0] RST_EDGE  = (RST_MODE == TRIG_EDGE)    ? IMPL_MASK : 32'h0;
   localparam logic [31:0] RST_LATCH = (RST_MODE == TRIG_LATCHED) ? IMPL_MASK : 32'h0;

   if (RST_MODE == TRIG_INVALID) begin : g_bad_trigger
      $error("mor1kx_pic_multimode: OPTION_PIC_TRIGGER must be LEVEL, EDGE or LATCHED_LEVEL");
   end

   logic [31:0] picmr_q, picmr_d;
   logic [31:0] picedge_q, picedge_d;
   logic [31:0] piclatch_q, piclatch_d;
   logic [31:0] sticky_q, sticky_d;
   logic [31:0] irq_prev_q;
   logic        pending_q;
   logic [PICID_ID_W-1:0] id_q;

   logic [31:0] irq_s;
   logic [31:0] unmasked;
   logic [31:0] level_lines;
   logic [31:0] clr_bits;
   logic [31:0] keep_bits;
   logic [31:0] picsr;
   logic [31:0] rd_dat;
   logic [10:0] ofs;
   logic        spr_we;
   logic        enc_valid;
   logic [PICID_ID_W-1:0] enc_id;
   logic        unused_addr_hi;

`ifdef MOR1KX_PIC_SYNC_EN
   logic [31:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_i & IMPL_MASK;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq_i & IMPL_MASK;
`endif

   assign ofs            = spr.spr_addr_i[10:0];
   assign unused_addr_hi = ^spr.spr_addr_i[15:11];
   assign spr_we         = spr.spr_access_i & spr.spr_we_i;

   assign unmasked    = irq_s & picmr_q;
   assign level_lines = ~picedge_q & ~piclatch_q & IMPL_MASK;
   assign clr_bits    = (spr_we && ofs == SPR_OFS_PICSR) ? (spr.spr_dat_i & IMPL_MASK) : 32'h0;
   assign keep_bits   = sticky_q & ~clr_bits;

   // Edge and latched sets are OR'ed after the clear, so a coincident set always survives.
   // Level lines hold their sticky bit at 0, which is what clears state on a move to level.
   always_comb begin
      sticky_d = ((picedge_q & ((unmasked & ~irq_prev_q) | keep_bits)) |
                  (~picedge_q & piclatch_q & (unmasked | keep_bits))) & IMPL_MASK;
   end

   assign picsr = ((level_lines & unmasked) | (~level_lines & sticky_q)) & IMPL_MASK;

   always_comb begin
      picmr_d    = picmr_q;
      picedge_d  = picedge_q;
      piclatch_d = piclatch_q;
      if (spr_we) begin
         case (ofs)
            SPR_OFS_PICMR:    picmr_d    = (spr.spr_dat_i | NMI_MASK) & IMPL_MASK;
            SPR_OFS_PICEDGE:  picedge_d  = spr.spr_dat_i & IMPL_MASK;
            SPR_OFS_PICLATCH: piclatch_d = spr.spr_dat_i & IMPL_MASK;
            default: ;
         endcase
      end
   end

   mor1kx_pic_prio_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio_enc (
      .req_i   (picsr[NUM_IRQ-1:0]),
      .valid_o (enc_valid),
      .id_o    (enc_id)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         picmr_q    <= NMI_MASK;
         picedge_q  <= RST_EDGE;
         piclatch_q <= RST_LATCH;
         sticky_q   <= '0;
         irq_prev_q <= '0;
         pending_q  <= 1'b0;
         id_q       <= '0;
      end else begin
         picmr_q    <= picmr_d;
         picedge_q  <= picedge_d;
         piclatch_q <= piclatch_d;
         sticky_q   <= sticky_d;
         irq_prev_q <= irq_s;
         pending_q  <= enc_valid;
         id_q       <= enc_id;
      end
   end

   always_comb begin
      rd_dat = 32'h0;
      if (spr.spr_access_i) begin
         case (ofs)
            SPR_OFS_PICMR:    rd_dat = picmr_q;
            SPR_OFS_PICSR:    rd_dat = picsr;
            SPR_OFS_PICEDGE:  rd_dat = picedge_q;
            SPR_OFS_PICLATCH: rd_dat = piclatch_q;
            SPR_OFS_PICID: begin
               rd_dat[PICID_PEND_BIT]                          = pending_q;
               rd_dat[PICID_ID_LSB +: PICID_ID_W]              = id_q;
            end
            default:          rd_dat = 32'h0;
         endcase
      end
   end

   assign spr.spr_bus_ack = spr.spr_access_i;
   assign spr.spr_dat_o   = rd_dat;
   assign spr_picmr_o     = picmr_q;
   assign spr_picsr_o     = picsr;
   assign irq_pending_o   = pending_q;
   assign irq_id_o        = id_q;

endmodule

// File: tb/tb_mor1kx_pic_multimode.sv
// tb/tb_mor1kx_pic_multimode.sv - directed self-checking bench for mor1kx_pic_multimode
module tb_mor1kx_pic_multimode;
   import mor1kx_pic_pkg::*;

`ifdef MOR1KX_PIC_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] irq = '0;
   logic [31:0] irq_b = '0;
   logic [31:0] picmr, picsr, picmr_b, picsr_b;
   logic        pend, pend_b;
   logic [4:0]  id, id_b;
   logic [31:0] rd;
   int          errors = 0;
   int          checks = 0;

   mor1kx_pic_multimode_if bus ();
   mor1kx_pic_multimode_if bus_b ();

   always #5 clk = ~clk;

   mor1kx_pic_multimode #(
      .NUM_IRQ(32), .OPTION_PIC_NMI_WIDTH(2), .OPTION_PIC_TRIGGER("LEVEL")
   ) dut (
      .clk(clk), .rst_n(rst_n), .spr(bus.slave), .irq_i(irq),
      .spr_picmr_o(picmr), .spr_picsr_o(picsr),
      .irq_pending_o(pend), .irq_id_o(id)
   );

   mor1kx_pic_multimode #(
      .NUM_IRQ(8), .OPTION_PIC_NMI_WIDTH(0), .OPTION_PIC_TRIGGER("EDGE")
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .spr(bus_b.slave), .irq_i(irq_b),
      .spr_picmr_o(picmr_b), .spr_picsr_o(picsr_b),
      .irq_pending_o(pend_b), .irq_id_o(id_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      for (int i = 0; i < SYNC_LAT; i++) tick();
      #1;
   endtask

   task automatic spr_write(input logic [10:0] ofs, input logic [31:0] dat);
      bus.spr_access_i = 1'b1;
      bus.spr_we_i     = 1'b1;
      bus.spr_addr_i   = {5'h12, ofs};
      bus.spr_dat_i    = dat;
      tick();
      bus.spr_access_i = 1'b0;
      bus.spr_we_i     = 1'b0;
   endtask

   task automatic spr_read(input logic [10:0] ofs, output logic [31:0] dat);
      bus.spr_access_i = 1'b1;
      bus.spr_we_i     = 1'b0;
      bus.spr_addr_i   = {5'h12, ofs};
      #1;
      dat = bus.spr_dat_o;
      check("ack", {31'b0, bus.spr_bus_ack}, 32'h1);
      bus.spr_access_i = 1'b0;
      #1;
   endtask

   task automatic b_access(input logic we, input logic [10:0] ofs, input logic [31:0] dat,
                           output logic [31:0] rdat);
      bus_b.spr_access_i = 1'b1;
      bus_b.spr_we_i     = we;
      bus_b.spr_addr_i   = {5'h12, ofs};
      bus_b.spr_dat_i    = dat;
      #1;
      rdat = bus_b.spr_dat_o;
      if (we) tick();
      bus_b.spr_access_i = 1'b0;
      bus_b.spr_we_i     = 1'b0;
      #1;
   endtask

   initial begin
      bus.spr_access_i = 0; bus.spr_we_i = 0; bus.spr_addr_i = 0; bus.spr_dat_i = 0;
      bus_b.spr_access_i = 0; bus_b.spr_we_i = 0; bus_b.spr_addr_i = 0; bus_b.spr_dat_i = 0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;

      // Reset state
      check("rst_picmr", picmr, 32'h0000_0003);
      check("rst_picsr", picsr, 32'h0);
      check("rst_pend", {31'b0, pend}, 32'h0);
      check("rst_id", {27'b0, id}, 32'h0);
      spr_read(SPR_OFS_PICEDGE, rd);  check("rst_edge", rd, 32'h0);
      spr_read(SPR_OFS_PICLATCH, rd); check("rst_latch", rd, 32'h0);
      check("dat_idle", bus.spr_dat_o, 32'h0);

      // Level line 4
      spr_write(SPR_OFS_PICMR, 32'h10);
      check("lvl_picmr", picmr, 32'h13);
      irq = 32'h10; settle();
      check("lvl_same_cycle", picsr, 32'h10);
      tick();
      check("lvl_id", {27'b0, id}, 32'd4);
      check("lvl_pend", {31'b0, pend}, 32'h1);
      spr_write(SPR_OFS_PICSR, 32'h10);
      check("lvl_w1c_ignored", picsr, 32'h10);
      irq = 32'h0; settle();
      check("lvl_drop", picsr, 32'h0);
      tick();

      // Edge line 0
      spr_write(SPR_OFS_PICEDGE, 32'h1);
      spr_write(SPR_OFS_PICMR, 32'h1);
      irq = 32'h1; settle();
      check("edge_not_yet", picsr, 32'h0);
      tick();
      check("edge_set", picsr, 32'h1);
      tick();
      check("edge_held", picsr, 32'h1);
      spr_write(SPR_OFS_PICSR, 32'h1);
      check("edge_cleared", picsr, 32'h0);
      tick();
      check("edge_no_reset_high", picsr, 32'h0);
      irq = 32'h0; settle(); tick();
      irq = 32'h1; settle(); tick();
      check("edge_second", picsr, 32'h1);
      irq = 32'h0; settle(); tick();
      irq = 32'h1; settle();
      spr_write(SPR_OFS_PICSR, 32'h1);
      check("edge_set_beats_clr", picsr, 32'h1);
      irq = 32'h0; settle();
      spr_write(SPR_OFS_PICSR, 32'h1);
      check("edge_final_clr", picsr, 32'h0);
      spr_write(SPR_OFS_PICEDGE, 32'h0);

      // Latched-level line 8
      spr_write(SPR_OFS_PICLATCH, 32'h100);
      spr_write(SPR_OFS_PICMR, 32'h100);
      irq = 32'h100; settle(); tick();
      irq = 32'h0; settle();
      check("latch_stays", picsr, 32'h100);
      tick();
      check("latch_stays2", picsr, 32'h100);
      check("latch_id", {27'b0, id}, 32'd8);
      irq = 32'h100; settle();
      spr_write(SPR_OFS_PICSR, 32'h100);
      check("latch_clr_high", picsr, 32'h100);
      irq = 32'h0; settle();
      spr_write(SPR_OFS_PICSR, 32'h100);
      check("latch_clr_low", picsr, 32'h0);

      // Moving to level drops the stored bit
      irq = 32'h100; settle(); tick();
      irq = 32'h0; settle();
      spr_write(SPR_OFS_PICLATCH, 32'h0);
      tick();
      spr_write(SPR_OFS_PICLATCH, 32'h100);
      check("mode_level_clears", picsr, 32'h0);
      spr_write(SPR_OFS_PICLATCH, 32'h0);

      // Priority
      spr_write(SPR_OFS_PICMR, 32'hFFFF_FFFF);
      check("prio_picmr", picmr, 32'hFFFF_FFFF);
      irq = 32'hA0; settle(); tick();
      check("prio_id5", {27'b0, id}, 32'd5);
      spr_read(SPR_OFS_PICID, rd); check("picid", rd, 32'h8000_0005);
      spr_read(SPR_OFS_PICSR, rd); check("picsr_rd", rd, 32'hA0);
      irq = 32'h80; settle();
      check("prio_latency", {27'b0, id}, 32'd5);
      tick();
      check("prio_id7", {27'b0, id}, 32'd7);
      spr_read(11'd7, rd); check("ofs7", rd, 32'h0);
      irq = 32'h0; settle(); tick();
      check("prio_idle", {31'b0, pend}, 32'h0);

      // Narrow instance, EDGE reset mode
      b_access(1'b0, SPR_OFS_PICEDGE, 32'h0, rd); check("b_rst_edge", rd, 32'h0000_00FF);
      b_access(1'b1, SPR_OFS_PICMR, 32'hFFFF_FFFF, rd);
      b_access(1'b0, SPR_OFS_PICMR, 32'h0, rd); check("b_picmr", rd, 32'h0000_00FF);
      b_access(1'b0, 11'd7, 32'h0, rd); check("b_ofs7", rd, 32'h0);

`ifdef MOR1KX_PIC_SYNC_EN
      irq = 32'h1; #1;
      check("sync_c0", picsr, 32'h0);
      tick();
      check("sync_c1", picsr, 32'h0);
      tick();
      check("sync_c2", picsr, 32'h1);
      irq = 32'h0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
